// File: rtl/fcr_regfile_ctrl.sv
// Byte-serial command/response front end driving a flat register file.
// Optional inter-byte timeout in PARSE is enabled with `define FCR_TIMEOUT_EN.
module fcr_regfile_ctrl #(
  parameter int unsigned ADR_BYTES   = 6,
  parameter int unsigned DATA_BYTES  = 9,
  parameter int unsigned NREG        = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_byte_req,
  input  logic [7:0]                   cmd_byte_data,
  output logic                         cmd_byte_ack,
  output logic                         rsp_byte_req,
  input  logic                         rsp_byte_ack,
  output logic [7:0]                   rsp_byte_data,
  output logic                         cmd_busy,
  input  logic [15:0]                  vnum,
  output logic [NREG*8*DATA_BYTES-1:0] reg_q,
  output logic                         reg_wr_stb,
  output logic [7:0]                   timeout_cnt
);

  localparam int unsigned DW = 8 * DATA_BYTES;
  localparam int unsigned AW = 8 * ADR_BYTES;
  localparam int unsigned FB = 2 + ADR_BYTES + DATA_BYTES;
  localparam int unsigned FW = 8 * FB;
  localparam int unsigned CW = $clog2(FB);
  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;
  // Range-check width keeps every address bit and still holds NREG=256
  localparam int unsigned RW = AW + 9;

  localparam logic [7:0] ACT_NOP  = 8'h00;
  localparam logic [7:0] ACT_GET  = 8'h01;
  localparam logic [7:0] ACT_SET  = 8'h02;
  localparam logic [7:0] PRM_VNUM = 8'h00;
  localparam logic [7:0] PRM_REG  = 8'h01;

  if (ADR_BYTES == 0 || ADR_BYTES > 8 || DATA_BYTES == 0 || DATA_BYTES > 9 ||
      NREG == 0 || NREG > 256 || TIMEOUT_CYC == 0) begin : g_param_check
    $error("fcr_regfile_ctrl: parameter out of legal range");
  end

  typedef enum logic [1:0] {S_IDLE, S_PARSE, S_EXE, S_RSP} state_t;

  state_t          state, state_nxt;
  logic [1:0]      cmd_req_sync, rsp_ack_sync;
  logic            cmd_req_d, rsp_ack_d;
  logic            req_s, ack_s, rsp_ack_fall;
  logic            byte_take, byte_done, exe_done, timeout_hit;
  logic [7:0]      cap_byte, act_q, param_q;
  logic [AW-1:0]   adr_q;
  logic [DW-1:0]   data_q;
  logic [CW-1:0]   byte_cnt, rsp_cnt;
  logic            exe_cnt;
  logic [FW-1:0]   rsp_buf;
  logic            adr_ok, err, wr_en;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   res;

  assign req_s        = cmd_req_sync[1];
  assign ack_s        = rsp_ack_sync[1];
  assign rsp_ack_fall = rsp_ack_d & ~ack_s;
  assign exe_done     = (state == S_EXE) && exe_cnt;

  // Two-flop synchronisers plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_req_sync <= 2'b00;
      rsp_ack_sync <= 2'b00;
      cmd_req_d    <= 1'b0;
      rsp_ack_d    <= 1'b0;
    end else begin
      cmd_req_sync <= {cmd_req_sync[0], cmd_byte_req};
      rsp_ack_sync <= {rsp_ack_sync[0], rsp_byte_ack};
      cmd_req_d    <= req_s;
      rsp_ack_d    <= ack_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake strobes
  always_comb begin
    state_nxt = state;
    byte_take = 1'b0;
    byte_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_s && !cmd_req_d) state_nxt = S_PARSE;
      end
      S_PARSE: begin
        if (timeout_hit) begin
          state_nxt = S_IDLE;
        end else if (req_s && !cmd_byte_ack) begin
          byte_take = 1'b1;
        end else if (!req_s && cmd_byte_ack) begin
          byte_done = 1'b1;
          if (byte_cnt == '0 && cap_byte > ACT_SET) state_nxt = S_IDLE;
          else if (byte_cnt == CW'(FB - 1))         state_nxt = S_EXE;
        end
      end
      S_EXE: begin
        if (exe_cnt) state_nxt = S_RSP;
      end
      S_RSP: begin
        if (rsp_ack_fall && rsp_cnt == CW'(FB - 1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command decode against the register file
  always_comb begin
    adr_ok = (RW'(adr_q) < RW'(NREG));
    idx    = adr_q[IW-1:0];
    err    = 1'b0;
    wr_en  = 1'b0;
    res    = '0;
    case (act_q)
      ACT_GET: begin
        if (param_q == PRM_VNUM)              res = DW'(vnum);
        else if (param_q == PRM_REG && adr_ok) res = reg_q[idx*DW +: DW];
        else                                  err = 1'b1;
      end
      ACT_SET: begin
        if (param_q == PRM_REG && adr_ok) begin
          wr_en = 1'b1;
          res   = data_q;
        end else begin
          err = 1'b1;
        end
      end
      ACT_NOP: ;
      default: ;
    endcase
  end

  // Command byte capture and field assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_byte_ack <= 1'b0;
      cap_byte     <= 8'h00;
      byte_cnt     <= '0;
      act_q        <= 8'h00;
      param_q      <= 8'h00;
      adr_q        <= '0;
      data_q       <= '0;
      exe_cnt      <= 1'b0;
      cmd_busy     <= 1'b0;
    end else begin
      cmd_busy <= (state_nxt != S_IDLE);
      exe_cnt  <= (state == S_EXE) && !exe_cnt;
      if (state == S_IDLE) byte_cnt <= '0;
      if (byte_take) begin
        cmd_byte_ack <= 1'b1;
        cap_byte     <= cmd_byte_data;
      end else if (byte_done || timeout_hit) begin
        cmd_byte_ack <= 1'b0;
      end
      if (byte_done) begin
        byte_cnt <= byte_cnt + CW'(1);
        if (byte_cnt == '0)                    act_q   <= cap_byte;
        else if (byte_cnt == CW'(1))           param_q <= cap_byte;
        else if (byte_cnt < CW'(2 + ADR_BYTES)) adr_q   <= AW'({adr_q, cap_byte});
        else                                   data_q  <= DW'({data_q, cap_byte});
      end
    end
  end

  // Register write and response frame serialisation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q         <= '0;
      reg_wr_stb    <= 1'b0;
      rsp_buf       <= '0;
      rsp_byte_data <= 8'h00;
      rsp_byte_req  <= 1'b0;
      rsp_cnt       <= '0;
    end else begin
      reg_wr_stb <= exe_done && wr_en;
      if (exe_done && wr_en) reg_q[idx*DW +: DW] <= data_q;
      if (exe_done) begin
        rsp_buf       <= {err, act_q[6:0], param_q, adr_q, res};
        rsp_byte_data <= {err, act_q[6:0]};
        rsp_byte_req  <= 1'b1;
        rsp_cnt       <= '0;
      end else if (state == S_RSP) begin
        if (rsp_byte_req && ack_s) rsp_byte_req <= 1'b0;
        if (rsp_ack_fall && rsp_cnt != CW'(FB - 1)) begin
          rsp_buf       <= rsp_buf << 8;
          rsp_byte_data <= rsp_buf[FW-9 -: 8];
          rsp_byte_req  <= 1'b1;
          rsp_cnt       <= rsp_cnt + CW'(1);
        end
      end
    end
  end

`ifdef FCR_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  assign timeout_hit = (state == S_PARSE) && (to_cnt == TW'(TIMEOUT_CYC - 1));

  // Idle-cycle counter restarts on PARSE entry and on every consumed byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      timeout_cnt <= 8'h00;
    end else begin
      if (state != S_PARSE || byte_done) to_cnt <= '0;
      else                               to_cnt <= to_cnt + TW'(1);
      if (timeout_hit && timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_cnt = 8'h00;
`endif

endmodule
